// File: rtl/reg_dump_reader_if.sv
// Byte stream carrying one register per transfer, with valid/ready flow control.
interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] index;
  logic              last;

  modport master (output valid, data, index, last, input ready);
  modport slave  (input valid, data, index, last, output ready);
endinterface

// File: rtl/reg_dump_reader.sv
// Snapshots the register file through its two read ports, one even/odd pair at a
// time, and streams every register as one byte tagged with its register number.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rd_addr1_o,
  output logic [ADDR_W-1:0] rd_addr2_o,
  input  logic [DATA_W-1:0] rd_data1_i,
  input  logic [DATA_W-1:0] rd_data2_i,
  reg_dump_reader_if.master out_if,
  output logic              busy_o,
  output logic              done_o
);
  localparam int PW = ADDR_W - 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(NUM_REGS / 2 - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SEND_A, SEND_B, DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     pair_q, pair_d;
  logic [DATA_W-1:0] holdA_q, holdB_q;
  logic [ADDR_W-1:0] rdAddr1_q, rdAddr2_q;
  logic              outValid, outLast, isLastPair;
  logic [DATA_W-1:0] outData;
  logic [ADDR_W-1:0] outIndex;

  assign isLastPair = (pair_q == LAST_PAIR);

  // Read addresses are loaded on entry to FETCH so they hold between fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      holdA_q   <= '0;
      holdB_q   <= '0;
      rdAddr1_q <= '0;
      rdAddr2_q <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      if (state_q == FETCH) begin
        holdA_q <= rd_data1_i;
        holdB_q <= rd_data2_i;
      end
      if (state_d == FETCH) begin
        rdAddr1_q <= {pair_d, 1'b0};
        rdAddr2_q <= {pair_d, 1'b1};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pair_d   = pair_q;
    outValid = 1'b0;
    outData  = '0;
    outIndex = '0;
    outLast  = 1'b0;
    done_o   = 1'b0;
    busy_o   = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          pair_d  = '0;
        end
      end
      FETCH: state_d = SEND_A;
      SEND_A: begin
        outValid = 1'b1;
        outData  = holdA_q;
        outIndex = {pair_q, 1'b0};
        if (out_if.ready) state_d = SEND_B;
      end
      SEND_B: begin
        outValid = 1'b1;
        outData  = holdB_q;
        outIndex = {pair_q, 1'b1};
        outLast  = isLastPair;
        if (out_if.ready) begin
          if (isLastPair) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            pair_d  = pair_q + 1'b1;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over any handshake or transition decided above.
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      pair_d  = '0;
    end
  end

  assign rd_addr1_o   = rdAddr1_q;
  assign rd_addr2_o   = rdAddr2_q;
  assign out_if.valid = outValid;
  assign out_if.data  = outData;
  assign out_if.index = outIndex;
  assign out_if.last  = outLast;
endmodule
